// File: rtl/xup_rr_arb6_pkg.sv
// xup_rr_arb6_pkg: shared state encodings, widths and modulo-6 helper for the 6-way round-robin arbiter
package xup_rr_arb6_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} st_t;
  localparam int NUM_REQ = 6;
  localparam int ID_W = 3;
  localparam int HOLD_W = 8;
  function automatic logic [ID_W-1:0] mod6_add(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    logic [ID_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd6) ? ID_W'(s - 4'd6) : ID_W'(s);
  endfunction
endpackage

// File: rtl/xup_or6.sv
// xup_or6: 6-input OR used as the request-detect path
module xup_or6 (
  input  logic [5:0] a,
  output logic       y
);
  assign y = |a;
endmodule

// File: rtl/xup_rr_pick6.sv
// xup_rr_pick6: rotate / priority-encode / un-rotate search starting after ptr
module xup_rr_pick6
  import xup_rr_arb6_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) rot[k] = req[mod6_add(ptr, ID_W'(k + 1))];
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = ID_W'(k);
    found = |rot;
    idx = mod6_add(ptr, off + 3'd1);
  end
endmodule

// File: rtl/xup_rr_arb6.sv
// xup_rr_arb6: registered round-robin arbiter for 6 requesters; XUP_ARB_TIMEOUT_EN adds forced release after MAX_HOLD cycles
// DELAY is kept for interface compatibility only; it never shapes the synthesized logic.
module xup_rr_arb6
  import xup_rr_arb6_pkg::*;
#(
  parameter int DELAY    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 gnt_valid,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 any_req,
  output logic                 expired
);
  st_t                st, st_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [ID_W-1:0]    ptr, ptr_n, id_n, idx;
  logic               found;
  logic               unused;
  assign unused = ^{DELAY[0], MAX_HOLD[0]};
  xup_or6 u_or (.a(req), .y(any_req));
  xup_rr_pick6 u_pick (.req(req), .ptr(ptr), .found(found), .idx(idx));
  assign gnt_valid = |gnt;
`ifdef XUP_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic              exp_n;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    st_n  = st;
    gnt_n = gnt;
    id_n  = gnt_id;
    ptr_n = ptr;
`ifdef XUP_ARB_TIMEOUT_EN
    cnt_n = cnt;
    exp_n = 1'b0;
`endif
    if (st == ST_IDLE) begin
      if (found) begin
        st_n  = ST_GRANT;
        gnt_n = 6'b1 << idx;
        id_n  = idx;
        ptr_n = idx;
`ifdef XUP_ARB_TIMEOUT_EN
        cnt_n = '0;
`endif
      end
    end else if (!req[gnt_id]) begin
      st_n  = ST_IDLE;
      gnt_n = '0;
`ifdef XUP_ARB_TIMEOUT_EN
    end else if (cnt == HOLD_W'(MAX_HOLD - 1)) begin
      st_n  = ST_IDLE;
      gnt_n = '0;
      exp_n = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      gnt    <= '0;
      gnt_id <= 3'd5;
      ptr    <= 3'd5;
    end else begin
      st     <= st_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
      ptr    <= ptr_n;
    end
  end
`ifdef XUP_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      expired <= exp_n;
    end
  end
`endif
endmodule
